// File: rtl/leg_pkg.sv
// Shared definitions for the LEG sequencer: FSM states, opcode field
// positions, the I/O operand code and operand-decoding helpers.
package leg_pkg;

    typedef enum logic [3:0] {
        F0,
        F1,
        F2,
        F3,
        F4,
        IN_WAIT,
        EXEC,
        OUT_WAIT,
        WB
    } state_t;

    localparam int IMM1_BIT = 7;
    localparam int IMM2_BIT = 6;
    localparam int JMP_BIT  = 5;
    localparam int FUNC_MSB = 3;

    localparam logic [7:0] IO_CODE     = 8'd7;
    localparam int         INSTR_BYTES = 4;

    // ALU/condition function field carried in the low opcode bits
    typedef logic [FUNC_MSB:0] func_t;

    // A register operand naming the I/O port needs one input handshake
    function automatic logic needs_in(input logic [7:0] op, input logic [7:0] a1,
                                      input logic [7:0] a2, input logic [7:0] io);
        return (!op[IMM1_BIT] && (a1 == io)) || (!op[IMM2_BIT] && (a2 == io));
    endfunction

    // Non-jump results addressed to the I/O port go out instead of to a register
    function automatic logic needs_out(input logic [7:0] op, input logic [7:0] dst,
                                       input logic [7:0] io);
        return !op[JMP_BIT] && (dst == io);
    endfunction

endpackage

// File: rtl/leg_seq_ctrl_if.sv
// Program-memory bus plus the input and output port handshakes of the sequencer.
interface leg_seq_ctrl_if;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic       in_req;
    logic       in_valid;
    logic       in_capture;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output prog_addr, in_req, in_capture, out_valid,
        input  prog_data, in_valid, out_ready
    );

    modport slave (
        input  prog_addr, in_req, in_capture, out_valid,
        output prog_data, in_valid, out_ready
    );
endinterface

// File: rtl/leg_ir_fetch.sv
// Instruction fetch: walks the four instruction bytes, drives the program
// address and latches each byte into its instruction-register field.
module leg_ir_fetch (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] pc,
    input  logic [7:0] prog_data,
    output logic [7:0] prog_addr,
    output logic [7:0] opcode,
    output logic [7:0] arg1,
    output logic [7:0] arg2,
    output logic [7:0] dest,
    output logic       fetch_done
);
    // 0 = idle at the instruction boundary; 1..4 = byte (cnt-1) arriving this cycle
    logic [2:0] cnt;

    // Byte counter: starts on the run decision, wraps back to idle after dest
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 3'd0;
        end else if (cnt == 3'd0) begin
            if (start) cnt <= 3'd1;
        end else if (cnt == 3'd4) begin
            cnt <= 3'd0;
        end else begin
            cnt <= cnt + 3'd1;
        end
    end

    // Field latch: memory read is registered, so the byte for address pc+k
    // is on prog_data while the counter reads k+1
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode <= 8'd0;
            arg1   <= 8'd0;
            arg2   <= 8'd0;
            dest   <= 8'd0;
        end else begin
            case (cnt)
                3'd1:    opcode <= prog_data;
                3'd2:    arg1   <= prog_data;
                3'd3:    arg2   <= prog_data;
                3'd4:    dest   <= prog_data;
                default: ;
            endcase
        end
    end

    assign prog_addr  = pc + {5'd0, cnt};
    assign fetch_done = (cnt == 3'd4);

endmodule

// File: rtl/leg_seq_ctrl.sv
// LEG core sequencer: fetches 4-byte instructions, stalls on the I/O
// handshakes, issues one write-back per instruction and advances the PC,
// redirecting it on a taken conditional jump.
module leg_seq_ctrl #(
    parameter logic [7:0] IO_CODE     = leg_pkg::IO_CODE,
    parameter int         INSTR_BYTES = leg_pkg::INSTR_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    leg_seq_ctrl_if.master        bus,
    output logic [7:0]            ir_opcode,
    output logic [7:0]            ir_arg1,
    output logic [7:0]            ir_arg2,
    output logic [7:0]            ir_dest,
    output logic [7:0]            pc,
    input  logic                  cond_true,
    output logic                  wb_en,
    output logic                  instr_done
);
    import leg_pkg::*;

    state_t state, state_n;
    logic   jmp_take;
    logic   fetch_done;
    logic   need_in;
    logic   need_out;

    assign need_in  = needs_in(ir_opcode, ir_arg1, ir_arg2, IO_CODE);
    assign need_out = needs_out(ir_opcode, ir_dest, IO_CODE);

    leg_ir_fetch u_fetch (
        .clk        (clk),
        .rst        (rst),
        .start      ((state == F0) && run),
        .pc         (pc),
        .prog_data  (bus.prog_data),
        .prog_addr  (bus.prog_addr),
        .opcode     (ir_opcode),
        .arg1       (ir_arg1),
        .arg2       (ir_arg2),
        .dest       (ir_dest),
        .fetch_done (fetch_done)
    );

    // State, PC and jump decision registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= F0;
            pc       <= 8'd0;
            jmp_take <= 1'b0;
        end else begin
            state <= state_n;
            if (state == EXEC) jmp_take <= ir_opcode[JMP_BIT] && cond_true;
            if (state == WB)   pc <= jmp_take ? ir_dest : pc + 8'(INSTR_BYTES);
        end
    end

    // Next-state and handshake/strobe decode; only in_capture looks at an input
    always_comb begin
        state_n        = state;
        bus.in_req     = 1'b0;
        bus.in_capture = 1'b0;
        bus.out_valid  = 1'b0;
        wb_en          = 1'b0;
        instr_done     = 1'b0;
        case (state)
            F0:       if (run) state_n = F1;
            F1:       state_n = F2;
            F2:       state_n = F3;
            F3:       state_n = F4;
            F4:       if (fetch_done) state_n = need_in ? IN_WAIT : EXEC;
            IN_WAIT: begin
                bus.in_req = 1'b1;
                if (bus.in_valid) begin
                    bus.in_capture = 1'b1;
                    state_n        = EXEC;
                end
            end
            EXEC:     state_n = need_out ? OUT_WAIT : WB;
            OUT_WAIT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_n = WB;
            end
            WB: begin
                wb_en      = !ir_opcode[JMP_BIT] && !need_out;
                instr_done = 1'b1;
                state_n    = F0;
            end
            default:  state_n = F0;
        endcase
    end

endmodule

// File: tb/tb_leg_seq_ctrl.sv
// Bench for leg_seq_ctrl: directed instructions from the test plan followed
// by randomized instructions, checked cycle by cycle against a timing model.
module tb_leg_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       cond_true;
    logic [7:0] ir_opcode, ir_arg1, ir_arg2, ir_dest, pc;
    logic       wb_en, instr_done;

    leg_seq_ctrl_if bus ();

    leg_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .bus        (bus),
        .ir_opcode  (ir_opcode),
        .ir_arg1    (ir_arg1),
        .ir_arg2    (ir_arg2),
        .ir_dest    (ir_dest),
        .pc         (pc),
        .cond_true  (cond_true),
        .wb_en      (wb_en),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    // Byte-wide program memory with a registered read
    logic [7:0] mem [256];
    always @(posedge clk) bus.prog_data <= mem[bus.prog_addr];

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] pc_m;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {bus.in_req, bus.in_capture, bus.out_valid, wb_en, instr_done};
    endfunction

    // Parked in F0 with run low: nothing moves
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            run          = 1'b0;
            bus.in_valid = 1'($urandom_range(1));
            bus.out_ready = 1'($urandom_range(1));
            cond_true    = 1'($urandom_range(1));
            #1;
            check_eq("idle_addr", bus.prog_addr, pc_m);
            check_eq("idle_strb", strobes(), 5'b0);
            check_eq("idle_pc", pc, pc_m);
        end
    endtask

    // One instruction at pc_m. n_in / n_out are the stall lengths; csel 0/1
    // forces cond_true in EXEC, 2 randomizes it.
    task automatic do_instr(input logic [7:0] op, input logic [7:0] a1, input logic [7:0] a2,
                            input logic [7:0] dst, input int n_in, input int n_out, input int csel);
        bit         nin, nout, jmp, cond_e;
        int         e, ob, w;
        logic [4:0] exp_s;
        nin  = (!op[7] && a1 == 8'd7) || (!op[6] && a2 == 8'd7);
        nout = !op[5] && dst == 8'd7;
        e    = 5 + (nin ? n_in + 1 : 0);
        ob   = e + 1;
        w    = ob + (nout ? n_out + 1 : 0);
        cond_e = 1'b0;
        mem[pc_m]        = op;
        mem[pc_m + 8'd1] = a1;
        mem[pc_m + 8'd2] = a2;
        mem[pc_m + 8'd3] = dst;
        for (int k = 0; k <= w; k++) begin
            @(negedge clk);
            run = (k == 0) ? 1'b1 : 1'($urandom_range(1));
            if (nin && k >= 5 && k < 5 + n_in)       bus.in_valid = 1'b0;
            else if (nin && k == 5 + n_in)           bus.in_valid = 1'b1;
            else                                     bus.in_valid = 1'($urandom_range(1));
            if (nout && k >= ob && k < ob + n_out)   bus.out_ready = 1'b0;
            else if (nout && k == ob + n_out)        bus.out_ready = 1'b1;
            else                                     bus.out_ready = 1'($urandom_range(1));
            cond_true = 1'($urandom_range(1));
            if (k == e && csel != 2) cond_true = 1'(csel);
            if (k == e) cond_e = cond_true;
            #1;
            exp_s[4] = nin && k >= 5 && k <= 5 + n_in;
            exp_s[3] = nin && k == 5 + n_in;
            exp_s[2] = nout && k >= ob && k <= ob + n_out;
            exp_s[1] = (k == w) && !op[5] && !nout;
            exp_s[0] = (k == w);
            check_eq("strobes", strobes(), exp_s);
            check_eq("pc_hold", pc, pc_m);
            if (k < 4) check_eq("prog_addr", bus.prog_addr, pc_m + 8'(k));
            if (k >= 5) check_eq("ir_fields", {ir_opcode, ir_arg1, ir_arg2, ir_dest},
                                 {op, a1, a2, dst});
        end
        jmp  = op[5] && cond_e;
        pc_m = jmp ? dst : pc_m + 8'd4;
        @(negedge clk);
        run = 1'b0;
        #1;
        check_eq("pc_next", pc, pc_m);
    endtask

    function automatic logic [7:0] rnd_arg();
        return ($urandom_range(3) == 0) ? 8'd7 : 8'($urandom);
    endfunction

    initial begin
        rst = 1'b1;
        run = 1'b0;
        cond_true = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        pc_m = 8'd0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_strb", strobes(), 5'b0);
        check_eq("rst_pc", pc, 8'd0);
        check_eq("rst_addr", bus.prog_addr, 8'd0);
        check_eq("rst_ir", {ir_opcode, ir_arg1, ir_arg2, ir_dest}, 32'd0);
        rst = 1'b0;

        // Directed cases
        do_instr(8'h80, 8'h05, 8'h00, 8'h01, 0, 0, 2);   // plain, pc 0 -> 4
        do_instr(8'h20, 8'h00, 8'h00, 8'h40, 0, 0, 1);   // taken jump -> 0x40
        do_instr(8'h20, 8'h00, 8'h00, 8'h10, 0, 0, 0);   // not taken -> 0x44
        do_instr(8'h01, 8'h07, 8'h07, 8'h02, 5, 0, 2);   // double input, 5-cycle stall
        do_instr(8'h42, 8'h03, 8'h09, 8'h07, 0, 3, 2);   // output, 3-cycle stall
        do_instr(8'h20, 8'h00, 8'h00, 8'hFC, 0, 0, 1);   // jump to 0xFC
        do_instr(8'hC0, 8'h11, 8'h22, 8'h03, 0, 0, 2);   // wraps to 0x00
        idle(4);                                          // run low: parked

        // Randomized instructions with random idle gaps
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(3) == 0) idle($urandom_range(3) + 1);
            do_instr(8'($urandom), rnd_arg(), rnd_arg(), rnd_arg(),
                     $urandom_range(4), $urandom_range(4), 2);
        end

        // Reset while waiting for input
        mem[pc_m]        = 8'h00;
        mem[pc_m + 8'd1] = 8'h07;
        mem[pc_m + 8'd2] = 8'h07;
        mem[pc_m + 8'd3] = 8'h01;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            run = (k == 0);
            bus.in_valid = 1'b0;
            #1;
            if (k >= 5) check_eq("rst_iw_req", bus.in_req, 1'b1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        pc_m = 8'd0;
        #1;
        check_eq("rst_mid_strb", strobes(), 5'b0);
        check_eq("rst_mid_pc", pc, 8'd0);
        check_eq("rst_mid_addr", bus.prog_addr, 8'd0);
        check_eq("rst_mid_ir", {ir_opcode, ir_arg1, ir_arg2, ir_dest}, 32'd0);
        idle(2);
        do_instr(8'h80, 8'h05, 8'h00, 8'h01, 0, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
